// File: rtl/arm_pkg.sv
// Shared definitions for the ARM block-transfer datapath.
// Holds the sequencer state encoding and the word size.
package arm_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StWb,
        StDone
    } seq_state_e;

endpackage

// File: rtl/prio_enc16.sv
// Lowest-set-bit priority encoder over a 16-bit vector.
// valid_o is low when no bit is set; idx_o is then 0.
module prio_enc16 (
    input  logic [15:0] in_i,
    output logic [3:0]  idx_o,
    output logic        valid_o
);

    // Scanning downwards lets the lowest set bit win.
    always_comb begin
        idx_o = '0;
        for (int i = 15; i >= 0; i--) begin
            if (in_i[i]) begin
                idx_o = 4'(i);
            end
        end
    end

    assign valid_o = |in_i;

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM block-transfer sequencer: walks the register list lowest-first,
// issuing one memory beat per register, then optionally writes back the base.
module ldm_stm_seq
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_load,
    input  logic        up,
    input  logic        pre,
    input  logic        wb,
    input  logic [3:0]  rn,
    input  logic [15:0] reglist,
    input  logic [31:0] base,
    output logic        busy,
    output logic        done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  rf_ra,
    input  logic [31:0] rf_rd,
    output logic        rf_we,
    output logic [3:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic        pc_we,
    output logic [31:0] pc_wd
);

    localparam logic [31:0] Step = 32'(WORD_BYTES);

    seq_state_e  state_q, state_d;
    logic [15:0] list_q, list_d;
    logic [3:0]  rn_q, rn_d;
    logic        load_q, load_d;
    logic        wb_q, wb_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] final_q, final_d;

    logic [4:0]  n_regs;
    logic [31:0] span;
    logic [31:0] start_addr;
    logic [3:0]  cur_idx;
    logic        cur_valid;

    prio_enc16 u_prio_enc16 (
        .in_i    (list_q),
        .idx_o   (cur_idx),
        .valid_o (cur_valid)
    );

    always_comb begin
        n_regs = '0;
        for (int i = 0; i < 16; i++) begin
            n_regs = n_regs + 5'(reglist[i]);
        end
    end

    assign span = 32'(n_regs) * Step;

    // Registers always go to ascending addresses; only the lowest one moves.
    always_comb begin
        unique case ({up, pre})
            2'b10:   start_addr = base;
            2'b11:   start_addr = base + Step;
            2'b00:   start_addr = base - span + Step;
            default: start_addr = base - span;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            list_q  <= '0;
            rn_q    <= '0;
            load_q  <= 1'b0;
            wb_q    <= 1'b0;
            addr_q  <= '0;
            final_q <= '0;
        end else begin
            state_q <= state_d;
            list_q  <= list_d;
            rn_q    <= rn_d;
            load_q  <= load_d;
            wb_q    <= wb_d;
            addr_q  <= addr_d;
            final_q <= final_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        list_d    = list_q;
        rn_d      = rn_q;
        load_d    = load_q;
        wb_d      = wb_q;
        addr_d    = addr_q;
        final_d   = final_q;
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rf_ra     = '0;
        rf_we     = 1'b0;
        rf_wa     = '0;
        rf_wd     = '0;
        pc_we     = 1'b0;
        pc_wd     = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    list_d  = reglist;
                    rn_d    = rn;
                    load_d  = is_load;
                    // A loaded base register overrides the writeback value.
                    wb_d    = wb && !(is_load && reglist[rn]);
                    addr_d  = start_addr;
                    final_d = up ? base + span : base - span;
                    state_d = (reglist == '0) ? StDone : StXfer;
                end
            end
            StXfer: begin
                mem_req   = cur_valid;
                mem_we    = !load_q;
                mem_addr  = addr_q;
                rf_ra     = cur_idx;
                mem_wdata = load_q ? '0 : rf_rd;
                if (mem_ready) begin
                    list_d = list_q & ~(16'd1 << cur_idx);
                    addr_d = addr_q + Step;
                    if (load_q) begin
                        if (cur_idx == 4'd15) begin
                            pc_we = 1'b1;
                            pc_wd = mem_rdata;
                        end else begin
                            rf_we = 1'b1;
                            rf_wa = cur_idx;
                            rf_wd = mem_rdata;
                        end
                    end
                    if (list_d == '0) begin
                        state_d = wb_q ? StWb : StDone;
                    end
                end
            end
            StWb: begin
                rf_we   = 1'b1;
                rf_wa   = rn_q;
                rf_wd   = final_q;
                state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q != StIdle);

endmodule
